// File: rtl/dbg_pkg.sv
// Shared opcodes, status codes and FSM state types for the debug executor.
// SEND_CSUM exists only when DBG_EXEC_CHECKSUM_EN is defined.
package dbg_pkg;

    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_PING  = 8'h03;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BUS_ERR = 8'h01;
    localparam logic [7:0] ST_TIMEOUT = 8'h02;
    localparam logic [7:0] ST_BAD_OP  = 8'h03;

    typedef enum logic [1:0] {
        EX_IDLE,
        EX_BUS_REQ,
        EX_SEND
    } exec_state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SEND_STATUS,
        SEND_DATA
`ifdef DBG_EXEC_CHECKSUM_EN
        ,
        SEND_CSUM
`endif
    } ser_state_t;

endpackage

// File: rtl/dbg_executor_if.sv
// Simple req/ack bus between the debug executor and the system fabric.
interface dbg_executor_if #(
    parameter int AdrW = 4,
    parameter int DatW = 4
);
    logic              req;
    logic              we;
    logic [AdrW*8-1:0] adr;
    logic [DatW*8-1:0] wdata;
    logic [DatW*8-1:0] rdata;
    logic              ack;
    logic              err;

    modport master (
        output req, we, adr, wdata,
        input  rdata, ack, err
    );

    modport slave (
        input  req, we, adr, wdata,
        output rdata, ack, err
    );
endinterface

// File: rtl/dbg_resp_ser.sv
// Response serialiser: status byte, optional read data (MSB first) and,
// with DBG_EXEC_CHECKSUM_EN, a trailing XOR checksum byte.
module dbg_resp_ser
    import dbg_pkg::*;
#(
    parameter int DatW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [7:0]        status,
    input  logic [DatW*8-1:0] rdata,
    input  logic              with_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              done
);
    localparam int IdxW = DatW > 1 ? $clog2(DatW) : 1;

`ifdef DBG_EXEC_CHECKSUM_EN
    localparam ser_state_t Tail = SEND_CSUM;
    logic [7:0] csum_q;
`else
    localparam ser_state_t Tail = SER_IDLE;
`endif

    ser_state_t        state_q, state_d;
    logic [7:0]        status_q;
    logic [DatW*8-1:0] rdata_q;
    logic              with_q;
    logic [IdxW-1:0]   idx_q;
    logic              xfer;

    assign tx_valid = state_q != SER_IDLE;
    assign xfer     = tx_valid && tx_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SER_IDLE:    if (load) state_d = SEND_STATUS;
            SEND_STATUS: if (xfer) state_d = with_q ? SEND_DATA : Tail;
            SEND_DATA:   if (xfer && idx_q == '0) state_d = Tail;
`ifdef DBG_EXEC_CHECKSUM_EN
            SEND_CSUM:   if (xfer) state_d = SER_IDLE;
`endif
            default:     state_d = SER_IDLE;
        endcase
        done = xfer && state_d == SER_IDLE;
    end

    always_comb begin
        tx_data = 8'h00;
        unique case (state_q)
            SEND_STATUS: tx_data = status_q;
            SEND_DATA:   tx_data = rdata_q[{idx_q, 3'b000} +: 8];
`ifdef DBG_EXEC_CHECKSUM_EN
            SEND_CSUM:   tx_data = csum_q;
`endif
            default:     tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SER_IDLE;
            status_q <= 8'h00;
            rdata_q  <= '0;
            with_q   <= 1'b0;
            idx_q    <= '0;
`ifdef DBG_EXEC_CHECKSUM_EN
            csum_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            if (load && state_q == SER_IDLE) begin
                status_q <= status;
                rdata_q  <= rdata;
                with_q   <= with_data;
                idx_q    <= IdxW'(DatW - 1);
`ifdef DBG_EXEC_CHECKSUM_EN
                csum_q   <= 8'h00;
`endif
            end else if (xfer) begin
                if (state_q == SEND_DATA) idx_q <= idx_q - 1'b1;
`ifdef DBG_EXEC_CHECKSUM_EN
                csum_q <= csum_q ^ tx_data;
`endif
            end
        end
    end

endmodule

// File: rtl/dbg_executor.sv
// Debug command executor: one bus access per command, byte-serial reply.
// Define DBG_EXEC_CHECKSUM_EN to append an XOR checksum byte to each reply.
module dbg_executor
    import dbg_pkg::*;
#(
    parameter int DatW             = 4,
    parameter int AdrW             = 4,
    parameter int BusTimeoutCycles = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [(1+AdrW+DatW)*8-1:0] cmd,
    input  logic                      cmd_valid,
    output logic                      busy,
    output logic                      overrun,
    dbg_executor_if.master            bus,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready
);
    localparam int CmdW = (1 + AdrW + DatW) * 8;
    localparam int CntW = $clog2(BusTimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(BusTimeoutCycles - 1);

    exec_state_t       state_q, state_d;
    logic [7:0]        op_q;
    logic [AdrW*8-1:0] adr_q;
    logic [DatW*8-1:0] dat_q;
    logic [DatW*8-1:0] rdata_q, rdata_d;
    logic [7:0]        status_q, status_d;
    logic [CntW-1:0]   cnt_q;
    logic              load_q, overrun_q;
    logic              fire, ser_done, req;
    logic [7:0]        cmd_op;
    logic              is_rw, is_nop;
    logic              got_err, got_ack, timed_out;

    assign cmd_op    = cmd[CmdW-1 -: 8];
    assign is_rw     = cmd_op == CMD_READ || cmd_op == CMD_WRITE;
    assign is_nop    = cmd_op == CMD_NOP || cmd_op == CMD_PING;

    // err outranks ack; timeout only counts when neither arrived
    assign got_err   = bus.err;
    assign got_ack   = bus.ack && !bus.err;
    assign timed_out = !bus.ack && !bus.err && cnt_q == CntLast;

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        rdata_d  = rdata_q;
        fire     = 1'b0;
        unique case (state_q)
            EX_IDLE: begin
                if (cmd_valid) begin
                    unique case (1'b1)
                        is_rw: state_d = EX_BUS_REQ;
                        is_nop: begin
                            status_d = ST_OK;
                            rdata_d  = '0;
                            fire     = 1'b1;
                        end
                        default: begin
                            status_d = ST_BAD_OP;
                            rdata_d  = '0;
                            fire     = 1'b1;
                        end
                    endcase
                end
            end
            EX_BUS_REQ: begin
                unique case (1'b1)
                    got_err: begin
                        status_d = ST_BUS_ERR;
                        rdata_d  = '0;
                        fire     = 1'b1;
                    end
                    got_ack: begin
                        status_d = ST_OK;
                        rdata_d  = bus.rdata;
                        fire     = 1'b1;
                    end
                    timed_out: begin
                        status_d = ST_TIMEOUT;
                        rdata_d  = '0;
                        fire     = 1'b1;
                    end
                    default: ;
                endcase
            end
            EX_SEND: if (ser_done) state_d = EX_IDLE;
            default: state_d = EX_IDLE;
        endcase
        if (fire) state_d = EX_SEND;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= EX_IDLE;
            op_q      <= 8'h00;
            adr_q     <= '0;
            dat_q     <= '0;
            rdata_q   <= '0;
            status_q  <= 8'h00;
            cnt_q     <= '0;
            load_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            rdata_q   <= rdata_d;
            load_q    <= fire;
            overrun_q <= cmd_valid && state_q != EX_IDLE;
            if (state_q == EX_IDLE && cmd_valid) begin
                op_q  <= cmd_op;
                adr_q <= cmd[DatW*8 +: AdrW*8];
                dat_q <= cmd[DatW*8-1:0];
            end
            if (state_q == EX_BUS_REQ && !fire) cnt_q <= cnt_q + 1'b1;
            else cnt_q <= '0;
        end
    end

    assign req       = state_q == EX_BUS_REQ;
    assign bus.req   = req;
    assign bus.we    = req && op_q == CMD_WRITE;
    assign bus.adr   = adr_q;
    assign bus.wdata = dat_q;
    assign busy      = state_q != EX_IDLE;
    assign overrun   = overrun_q;

    // load lags the bus response by one cycle so status/rdata are registered
    dbg_resp_ser #(
        .DatW(DatW)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (load_q),
        .status   (status_q),
        .rdata    (rdata_q),
        .with_data(op_q == CMD_READ && status_q == ST_OK),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (ser_done)
    );

endmodule
